// File: rtl/sar_r2r_adc.sv
// sar_r2r_adc: successive-approximation ADC controller driving an R2R ladder, with block averaging of results
module sar_r2r_adc #(
  parameter int WIDTH = 8,
  parameter int SETTLE_CYCLES = 1000,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             comp_in,
  output logic [WIDTH-1:0] R2R_output,
  output logic [WIDTH-1:0] adc_result,
  output logic             result_valid,
  output logic [WIDTH-1:0] avg_result,
  output logic             avg_valid,
  output logic             busy
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int AW = WIDTH + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  typedef enum logic [2:0] {IDLE, START, SETTLE, DECIDE, DONE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc, sum;
  logic [NW-1:0] n_s;
  logic [WIDTH-1:0] mask, kept;
  logic comp_s, last;
  if (SETTLE_CYCLES < SYNC_STAGES + 1 || SYNC_STAGES < 2 || AVG_LOG2 < 0 || AVG_LOG2 > 8) begin : g_bad_cfg
    $error("sar_r2r_adc: illegal parameter combination");
  end
  always_comb begin
    comp_s = sync[SYNC_STAGES-1];
    mask = WIDTH'(1) << idx;
    kept = comp_s ? R2R_output : R2R_output & ~mask;
    sum = acc + AW'(adc_result);
    last = n_s == NW'(2**AVG_LOG2 - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sync <= '0;
      idx <= '0;
      cnt <= '0;
      acc <= '0;
      n_s <= '0;
      R2R_output <= '0;
      adc_result <= '0;
      result_valid <= 1'b0;
      avg_result <= '0;
      avg_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], comp_in};
      result_valid <= 1'b0;
      avg_valid <= 1'b0;
      if (state != IDLE && !enable) begin
        state <= IDLE;
        R2R_output <= '0;
        busy <= 1'b0;
        acc <= '0;
        n_s <= '0;
      end else begin
        case (state)
          IDLE: begin
            R2R_output <= '0;
            state <= enable ? START : IDLE;
            busy <= enable;
          end
          START: begin
            idx <= IW'(WIDTH - 1);
            R2R_output <= WIDTH'(1) << (WIDTH - 1);
            cnt <= CW'(SETTLE_CYCLES - 1);
            state <= SETTLE;
          end
          SETTLE: begin
            cnt <= cnt - 1'b1;
            state <= cnt == '0 ? DECIDE : SETTLE;
          end
          DECIDE: begin
            if (idx != '0) begin
              idx <= idx - 1'b1;
              R2R_output <= kept | (mask >> 1);
              cnt <= CW'(SETTLE_CYCLES - 1);
              state <= SETTLE;
            end else begin
              R2R_output <= kept;
              adc_result <= kept;
              result_valid <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            acc <= last ? '0 : sum;
            n_s <= last ? '0 : n_s + 1'b1;
            avg_result <= last ? WIDTH'(sum >> AVG_LOG2) : avg_result;
            avg_valid <= last;
            state <= START;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sar_r2r_adc.sv
// tb_sar_r2r_adc: directed bench for sar_r2r_adc with an ideal comparator comp_in = (R2R_output <= vin)
module tb_sar_r2r_adc;
  logic clk, reset, enable, comp_in;
  logic [7:0] vin;
  logic [7:0] R2R_output, adc_result, avg_result;
  logic result_valid, avg_valid, busy;
  int n_cmp = 0, n_bad = 0, n_avg = 0, n_rv = 0, n_idle = 0, n;
  logic [7:0] seq [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
  sar_r2r_adc #(.WIDTH(8), .SETTLE_CYCLES(4), .SYNC_STAGES(2), .AVG_LOG2(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .comp_in(comp_in),
    .R2R_output(R2R_output), .adc_result(adc_result), .result_valid(result_valid),
    .avg_result(avg_result), .avg_valid(avg_valid), .busy(busy)
  );
  assign comp_in = R2R_output <= vin;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (avg_valid) n_avg++;
    if (result_valid) n_rv++;
    if (!busy) n_idle++;
  endtask
  task automatic wait_rv(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!result_valid && k < 200);
    check("rv_timeout", {31'd0, result_valid}, 32'd1);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_r2r"}, R2R_output, 0);
    check({tag, "_adc"}, adc_result, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_avg"}, avg_result, 0);
    check({tag, "_avgv"}, avg_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask
  initial begin
    reset = 1'b1;
    enable = 1'b0;
    vin = 8'h00;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    vin = 8'hA5;
    enable = 1'b1;
    tick();
    check("start_busy", busy, 1);
    check("start_r2r", R2R_output, 0);
    for (int c = 2; c <= 41; c++) begin
      tick();
      check($sformatf("a5_r2r_c%0d", c), R2R_output, seq[(c - 2) / 5]);
    end
    check("a5_rv_c41", result_valid, 0);
    tick();
    check("a5_rv_c42", result_valid, 1);
    check("a5_adc", adc_result, 8'hA5);
    check("a5_r2r_done", R2R_output, 8'hA5);
    n_idle = 0;
    vin = 8'hFF;
    wait_rv(n);
    check("ff_period", n, 42);
    check("ff_adc", adc_result, 8'hFF);
    vin = 8'h00;
    wait_rv(n);
    check("00_period", n, 42);
    check("00_adc", adc_result, 8'h00);
    check("busy_held", n_idle, 0);
    vin = 8'h33;
    wait_rv(n);
    check("33_adc", adc_result, 8'h33);
    repeat (20) tick();
    check("abort_c20_r2r", R2R_output, 8'h30);
    check("abort_c20_busy", busy, 1);
    enable = 1'b0;
    n_rv = 0;
    tick();
    check("abort_c21_r2r", R2R_output, 0);
    check("abort_c21_busy", busy, 0);
    repeat (60) tick();
    check("abort_no_rv", n_rv, 0);
    check("abort_adc_hold", adc_result, 8'h33);
    check("abort_avg_hold", avg_result, 0);
    check("abort_no_avgv", n_avg, 0);
    vin = 8'h10;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_rv(n);
      check($sformatf("avg_adc_%0d", i), adc_result, i % 2 == 1 ? 8'h11 : 8'h10);
      vin = i % 2 == 1 ? 8'h10 : 8'h11;
    end
    check("avg_none_early", n_avg, 0);
    tick();
    check("avg_valid", avg_valid, 1);
    check("avg_result", avg_result, 8'h10);
    tick();
    check("avg_valid_drop", avg_valid, 0);
    check("avg_once", n_avg, 1);
    tick();
    vin = 8'h5C;
    reset = 1'b1;
    tick();
    check_zero("midreset");
    reset = 1'b0;
    wait_rv(n);
    check("rst_period", n, 42);
    check("rst_adc", adc_result, 8'h5C);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
